// File: rtl/fp_accum_pkg.sv
// Shared definitions for the fp_accum slice: FSM states, adder latency and
// partial-sum slot count.
package fp_accum_pkg;

  localparam int ADD_LAT = 3;
  localparam int NSLOT   = 3;

  typedef enum logic [2:0] {
    ACCUM,
    DRAIN,
    RED1,
    RED1_W,
    RED2,
    RED2_W,
    OUT
  } state_t;

  function automatic logic [1:0] next_slot(input logic [1:0] s);
    return (s == 2'(NSLOT - 1)) ? 2'd0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/fp_accum_if.sv
// Element/result stream bundle for fp_accum. Both streams use valid/ready:
// a beat moves on a rising edge with valid && ready, the source holds its
// payload stable until then, and ready never depends on valid.
interface fp_accum_if #(
  parameter int I_DATA = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [I_DATA-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [I_DATA-1:0] out_data;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fp_accum_fp_add.sv
// Three-stage floating-point adder (align, add, normalise); denormals flush to
// zero, rounding is truncation, no inf/NaN inputs are expected.
module fp_add #(
  parameter int I_EXP   = 8,
  parameter int I_MNT   = 23,
  parameter bit ADD_SUB = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [I_EXP+I_MNT:0]       a,
  input  logic [I_EXP+I_MNT:0]       b,
  output logic [I_EXP+I_MNT:0]       y
);
  localparam int I_DATA = I_EXP + I_MNT + 1;
  localparam int GRD    = 3;
  localparam int MW     = I_MNT + 1 + GRD;
  localparam int LZ_W   = I_EXP + 1;

  logic              a_big, b_sign;
  logic [I_DATA-1:0] big, sml;
  logic [I_EXP-1:0]  d;
  logic [MW-1:0]     mb, ms;

  logic              s1_sign, s1_sub, s1_zero;
  logic [I_EXP-1:0]  s1_exp;
  logic [MW-1:0]     s1_mb, s1_ms;
  logic              s2_sign, s2_zero;
  logic [I_EXP-1:0]  s2_exp;
  logic [MW:0]       s2_sum;

  logic [LZ_W-1:0]   lz, exp_w, e_up, e_dn;
  logic [MW-1:0]     norm;
  logic [I_DATA-1:0] y_nxt;

  // Larger magnitude first, so the sum keeps its sign and exponent.
  always_comb begin
    b_sign = b[I_DATA-1] ^ ADD_SUB;
    a_big  = a[I_DATA-2:0] >= b[I_DATA-2:0];
    big    = a_big ? a : {b_sign, b[I_DATA-2:0]};
    sml    = a_big ? {b_sign, b[I_DATA-2:0]} : a;
    d      = big[I_DATA-2:I_MNT] - sml[I_DATA-2:I_MNT];
    mb     = {1'b1, big[I_MNT-1:0], {GRD{1'b0}}};
    ms     = {1'b1, sml[I_MNT-1:0], {GRD{1'b0}}} >> d;
    if (sml[I_DATA-2:I_MNT] == '0) ms = '0;
  end

  always_comb begin
    lz = LZ_W'(MW);
    for (int i = 0; i < MW; i++) begin
      if (s2_sum[i]) lz = LZ_W'(MW - 1 - i);
    end
    norm  = s2_sum[MW-1:0] << lz;
    exp_w = {1'b0, s2_exp};
    e_up  = exp_w + LZ_W'(1);
    e_dn  = exp_w - lz;
    y_nxt = '0;
    if (s2_zero || s2_sum == '0) begin
      y_nxt = '0;
    end else if (s2_sum[MW]) begin
      if (e_up >= {1'b0, {I_EXP{1'b1}}})
        y_nxt = {s2_sign, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
      else
        y_nxt = {s2_sign, e_up[I_EXP-1:0], I_MNT'(s2_sum >> (GRD + 1))};
    end else if (exp_w > lz) begin
      y_nxt = {s2_sign, e_dn[I_EXP-1:0], I_MNT'(norm >> GRD)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sign <= 1'b0;
      s1_sub  <= 1'b0;
      s1_zero <= 1'b1;
      s1_exp  <= '0;
      s1_mb   <= '0;
      s1_ms   <= '0;
      s2_sign <= 1'b0;
      s2_zero <= 1'b1;
      s2_exp  <= '0;
      s2_sum  <= '0;
      y       <= '0;
    end else if (en) begin
      s1_sign <= big[I_DATA-1];
      s1_sub  <= big[I_DATA-1] ^ sml[I_DATA-1];
      s1_zero <= big[I_DATA-2:I_MNT] == '0;
      s1_exp  <= big[I_DATA-2:I_MNT];
      s1_mb   <= mb;
      s1_ms   <= ms;
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_exp  <= s1_exp;
      s2_sum  <= s1_sub ? ({1'b0, s1_mb} - {1'b0, s1_ms})
                        : ({1'b0, s1_mb} + {1'b0, s1_ms});
      y       <= y_nxt;
    end
  end

endmodule

// File: rtl/fp_accum.sv
// Streaming float vector summer: elements round-robin over three partial-sum
// slots so the 3-cycle adder stays full, then the slots are reduced pairwise.
module fp_accum
  import fp_accum_pkg::*;
#(
  parameter int I_EXP = 8,
  parameter int I_MNT = 23,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  fp_accum_if.slave    bus,
  output state_t       dbg_state
);
  localparam int I_DATA = I_EXP + I_MNT + 1;

  state_t                       state;
  logic [I_DATA-1:0]            slot_q [NSLOT];
  logic [NSLOT-1:0]             busy;
  logic [1:0]                   tgt;
  logic [ADD_LAT-1:0]           tag_v;
  logic [ADD_LAT-1:0][1:0]      tag_s;
  logic [1:0]                   wait_cnt;
  logic [CNT_W-1:0]             count;
  logic                         out_valid_q;
  logic [I_DATA-1:0]            out_data_q;
  logic [I_DATA-1:0]            add_a, add_b, add_y;
  logic                         ret_v, fwd, accept;
  logic [1:0]                   ret_s;

  assign ret_v = tag_v[ADD_LAT-1];
  assign ret_s = tag_s[ADD_LAT-1];
  // A slot whose result lands this cycle can take the next element directly.
  assign fwd   = ret_v && (ret_s == tgt);

  assign bus.in_ready  = !reset && (state == ACCUM) && (!busy[tgt] || fwd);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = count;
  assign dbg_state     = state;

  always_comb begin
    add_a = fwd ? add_y : slot_q[tgt];
    add_b = bus.in_data;
    if (state == RED1) begin
      add_a = slot_q[0];
      add_b = slot_q[1];
    end else if (state == RED2) begin
      add_a = slot_q[0];
      add_b = slot_q[2];
    end
  end

  fp_add #(
    .I_EXP  (I_EXP),
    .I_MNT  (I_MNT),
    .ADD_SUB(1'b0)
  ) u_add (
    .clk  (clk),
    .reset(reset),
    .en   (1'b1),
    .a    (add_a),
    .b    (add_b),
    .y    (add_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACCUM;
      slot_q      <= '{default: '0};
      busy        <= '0;
      tag_v       <= '0;
      tag_s       <= '0;
      tgt         <= '0;
      wait_cnt    <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      tag_v <= {tag_v[ADD_LAT-2:0], accept};
      tag_s <= {tag_s[ADD_LAT-2:0], tgt};
      if (ret_v) begin
        slot_q[ret_s] <= add_y;
        busy[ret_s]   <= 1'b0;
      end
      if (accept) begin
        busy[tgt] <= 1'b1;
        tgt       <= next_slot(tgt);
        if (count != '1) count <= count + CNT_W'(1);
      end
      case (state)
        ACCUM:  if (accept && bus.in_last) state <= DRAIN;
        DRAIN:  if (busy == '0) state <= RED1;
        RED1: begin
          wait_cnt <= '0;
          state    <= RED1_W;
        end
        RED1_W: begin
          // Slot 0 is reused to hold P0+P1 for the second reduction step.
          if (wait_cnt == 2'(ADD_LAT - 1)) begin
            slot_q[0] <= add_y;
            state     <= RED2;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        RED2: begin
          wait_cnt <= '0;
          state    <= RED2_W;
        end
        RED2_W: begin
          if (wait_cnt == 2'(ADD_LAT - 1)) begin
            out_data_q  <= add_y;
            out_valid_q <= 1'b1;
            state       <= OUT;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            slot_q      <= '{default: '0};
            busy        <= '0;
            tag_v       <= '0;
            tgt         <= '0;
            count       <= '0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum.sv
// Directed and randomized checks of fp_accum against an integer-sum model
// converted to single-precision bits.
module tb_fp_accum;
  import fp_accum_pkg::*;

  localparam int I_EXP  = 8;
  localparam int I_MNT  = 23;
  localparam int I_DATA = 32;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  fp_accum_if #(.I_DATA(I_DATA), .CNT_W(CNT_W)) bus ();

  fp_accum #(
    .I_EXP(I_EXP),
    .I_MNT(I_MNT),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int unsigned vec_q[$];
  logic [CNT_W+I_DATA-1:0] exp_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [31:0] int_to_f32(input int unsigned n);
    int p;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    p = 31;
    while (n[p] == 1'b0) p--;
    m = n << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input int n);
    return (n >= int'(CNT_MAX)) ? CNT_MAX : CNT_W'(n);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_vec(input int n, input int unsigned v [8]);
    vec_q.delete();
    for (int i = 0; i < n; i++) vec_q.push_back(v[i]);
  endtask

  task automatic send_vector(input int gap_max, input bit with_last, input bit chk_b2b);
    int unsigned sum;
    int n;
    int t;
    int idle;
    logic rdy;
    sum = 0;
    n = vec_q.size();
    for (int i = 0; i < n; i++) begin
      idle = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (idle) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = int_to_f32(vec_q[i]);
      bus.in_last  = with_last && (i == n - 1);
      t = 0;
      rdy = 1'b0;
      while (!rdy && t < 50) begin
        #1;
        rdy = bus.in_ready;
        if (chk_b2b) check("in_ready_b2b", rdy, 1'b1);
        @(negedge clk);
        t++;
      end
      if (!rdy) check("accept_timeout", rdy, 1'b1);
      sum += vec_q[i];
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (with_last) exp_q.push_back({sat_cnt(n), int_to_f32(sum)});
  endtask

  // scoreboard side: wait for the result, hold it, then take it
  task automatic collect(input int stall, output logic [I_DATA-1:0] got_d,
                         output logic [CNT_W-1:0] got_c);
    int lat;
    logic [CNT_W+I_DATA-1:0] e;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_rise", bus.out_valid, 1'b1);
    check("latency_le_12", lat <= 12, 1'b1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_in_ready", bus.in_ready, 1'b0);
      check("hold_data", bus.out_data, e[I_DATA-1:0]);
      @(negedge clk);
    end
    check("out_data", bus.out_data, e[I_DATA-1:0]);
    check("out_count", bus.out_count, e[CNT_W+I_DATA-1:I_DATA]);
    got_d = bus.out_data;
    got_c = bus.out_count;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("after_hs_valid", bus.out_valid, 1'b0);
    check("after_hs_state", dbg_state, ACCUM);
  endtask

  initial begin
    logic [I_DATA-1:0] d;
    logic [CNT_W-1:0]  c;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_out_count", bus.out_count, 4'h0);
    check("rst_state", dbg_state, ACCUM);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1'b1);

    // four ones back-to-back
    set_vec(4, '{1, 1, 1, 1, 0, 0, 0, 0});
    send_vector(0, 1'b1, 1'b1);
    collect(0, d, c);
    check("ones4_data", d, 32'h40800000);
    check("ones4_count", c, 4'd4);

    // 1..8 back-to-back, every slot reused through forwarding
    set_vec(8, '{1, 2, 3, 4, 5, 6, 7, 8});
    send_vector(0, 1'b1, 1'b1);
    collect(0, d, c);
    check("seq8_data", d, 32'h42100000);
    check("seq8_count", c, 4'd8);

    // single element passes through unchanged
    set_vec(1, '{5, 0, 0, 0, 0, 0, 0, 0});
    send_vector(0, 1'b1, 1'b0);
    collect(0, d, c);
    check("single_data", d, 32'h40A00000);
    check("single_count", c, 4'd1);

    // gapped input, result held under back-pressure
    set_vec(3, '{1, 2, 3, 0, 0, 0, 0, 0});
    send_vector(3, 1'b1, 1'b0);
    collect(5, d, c);
    check("stall_data", d, 32'h40C00000);
    check("stall_count", c, 4'd3);

    // reset with adds in flight discards the partial vector
    set_vec(2, '{2, 2, 0, 0, 0, 0, 0, 0});
    send_vector(0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 1'b0);
    repeat (2) @(negedge clk);
    check("midrst_state", dbg_state, ACCUM);
    check("midrst_count", bus.out_count, 4'h0);
    reset = 1'b0;
    set_vec(1, '{3, 0, 0, 0, 0, 0, 0, 0});
    send_vector(0, 1'b1, 1'b0);
    collect(0, d, c);
    check("midrst_data", d, 32'h40400000);
    check("midrst_count1", c, 4'd1);

    // consecutive vectors must not leak slot contents
    set_vec(2, '{1, 2, 0, 0, 0, 0, 0, 0});
    send_vector(0, 1'b1, 1'b0);
    collect(0, d, c);
    check("vecA_data", d, 32'h40400000);
    set_vec(2, '{4, 1, 0, 0, 0, 0, 0, 0});
    send_vector(0, 1'b1, 1'b0);
    collect(0, d, c);
    check("vecB_data", d, 32'h40A00000);
    check("vecB_count", c, 4'd2);

    // count saturates at all-ones
    vec_q.delete();
    repeat (20) vec_q.push_back(1);
    send_vector(0, 1'b1, 1'b1);
    collect(0, d, c);
    check("sat_data", d, 32'h41A00000);
    check("sat_count", c, CNT_MAX);

    // randomized vectors against the model
    for (int r = 0; r < 8; r++) begin
      vec_q.delete();
      n = int'($urandom_range(10, 1));
      repeat (n) vec_q.push_back($urandom_range(100, 1));
      send_vector(int'($urandom_range(2, 0)), 1'b1, 1'b0);
      collect(int'($urandom_range(3, 0)), d, c);
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
